// File: rtl/proc_control_pkg.sv
// Shared opcode, state and bus-select encodings for the processor control path.
package proc_control_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;

  // Bus mux codes; R0-R7 use their own index 0-7.
  localparam logic [3:0] SEL_G   = 4'd8;
  localparam logic [3:0] SEL_DIN = 4'd9;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_e;

endpackage

// File: rtl/proc_control_dec3to8.sv
// 3-to-8 one-hot decoder with enable, drives the register load enables.
module dec3to8 (
  input  logic [2:0] idx,
  input  logic       en,
  output logic [7:0] y
);

  always_comb begin
    y = '0;
    if (en) y[idx] = 1'b1;
  end

endmodule

// File: rtl/proc_control.sv
// Control FSM for the 16-bit processor: fetches a 9-bit instruction and
// sequences bus select, register/A/G loads and the ALU op over T0-T3.
module proc_control #(
  parameter int unsigned NREG    = 8,
  parameter logic [3:0]  SEL_G   = proc_control_pkg::SEL_G,
  parameter logic [3:0]  SEL_DIN = proc_control_pkg::SEL_DIN
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            run,
  input  logic [8:0]      ir,
  input  logic            g_nz,
  output logic            ir_in,
  output logic [NREG-1:0] r_in,
  output logic            a_in,
  output logic            g_in,
  output logic            add_sub,
  output logic [3:0]      select,
  output logic            done
);

  import proc_control_pkg::*;

  state_e     state, next_state;
  logic [2:0] op, xxx, yyy;
  logic       r_en;
  logic [7:0] r_dec;

  assign op  = ir[8:6];
  assign xxx = ir[5:3];
  assign yyy = ir[2:0];

  always_ff @(posedge clock) begin
    if (!resetn) state <= T0;
    else         state <= next_state;
  end

  // Outputs are held at defaults while resetn is low so that a fetch or
  // write cannot be issued in the same cycle the reset is being applied.
  always_comb begin
    next_state = T0;
    ir_in      = 1'b0;
    r_en       = 1'b0;
    a_in       = 1'b0;
    g_in       = 1'b0;
    add_sub    = 1'b0;
    select     = SEL_DIN;
    done       = 1'b0;
    if (resetn) begin
      case (state)
        T0: begin
          if (run) begin
            ir_in      = 1'b1;
            next_state = T1;
          end else begin
            next_state = T0;
          end
        end
        T1: begin
          case (op)
            OP_MV: begin
              select = {1'b0, yyy};
              r_en   = 1'b1;
              done   = 1'b1;
            end
            OP_MVI: begin
              r_en = 1'b1;
              done = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              select     = {1'b0, xxx};
              a_in       = 1'b1;
              next_state = T2;
            end
            OP_MVNZ: begin
              done = 1'b1;
              if (g_nz) begin
                select = {1'b0, yyy};
                r_en   = 1'b1;
              end
            end
            default: done = 1'b1;
          endcase
        end
        T2: begin
          select     = {1'b0, yyy};
          g_in       = 1'b1;
          add_sub    = op[0];
          next_state = T3;
        end
        T3: begin
          select = SEL_G;
          r_en   = 1'b1;
          done   = 1'b1;
        end
        default: next_state = T0;
      endcase
    end
  end

  dec3to8 u_dec (
    .idx (xxx),
    .en  (r_en),
    .y   (r_dec)
  );

  assign r_in = r_dec[NREG-1:0];

endmodule

// File: tb/tb_proc_control.sv
// Directed bench for proc_control with a small behavioural datapath model
// (register file, A, G, bus mux) driven from the controller outputs.
module tb_proc_control;

  logic        clock = 1'b0;
  logic        resetn, run, g_nz;
  logic [8:0]  ir;
  logic        ir_in, a_in, g_in, add_sub, done;
  logic [7:0]  r_in;
  logic [3:0]  select;
  logic [15:0] din;

  int vectors    = 0;
  int miscompares = 0;

  logic [16:0] obs, exp_v;
  localparam logic [16:0] IDLE = {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd9, 1'b0};
  localparam logic [16:0] FETCH = {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd9, 1'b0};

  assign obs = {ir_in, r_in, a_in, g_in, add_sub, select, done};

  proc_control #(.NREG(8), .SEL_G(4'd8), .SEL_DIN(4'd9)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .run     (run),
    .ir      (ir),
    .g_nz    (g_nz),
    .ir_in   (ir_in),
    .r_in    (r_in),
    .a_in    (a_in),
    .g_in    (g_in),
    .add_sub (add_sub),
    .select  (select),
    .done    (done)
  );

  always #5 clock = ~clock;

  // Datapath model
  logic [15:0] regs [8];
  logic [15:0] a_reg, g_reg, bus;
  logic        model_clr = 1'b1;

  always_comb begin
    if (select < 4'd8)       bus = regs[select[2:0]];
    else if (select == 4'd8) bus = g_reg;
    else if (select == 4'd9) bus = din;
    else                     bus = '0;
  end

  always @(posedge clock) begin
    if (model_clr) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      a_reg <= '0;
      g_reg <= '0;
    end else begin
      for (int i = 0; i < 8; i++) if (r_in[i]) regs[i] <= bus;
      if (a_in) a_reg <= bus;
      if (g_in) g_reg <= add_sub ? a_reg - bus : a_reg + bus;
    end
  end

  // Per-cycle structural property: r_in one-hot/zero, at most one load enable.
  always begin
    @(negedge clock);
    #3;
    if (!($onehot0(r_in) && ($countones({ir_in, a_in, g_in, |r_in}) <= 1))) begin
      miscompares++;
      $display("FAIL enable_onehot: r_in=%b ir_in=%b a_in=%b g_in=%b, want r_in one-hot/zero and at most one enable",
               r_in, ir_in, a_in, g_in);
    end
    vectors++;
  end

  task automatic test_reset();
    resetn = 1'b0; run = 1'b1; g_nz = 1'b0; din = '0;
    ir = 9'b001_010_000;
    repeat (2) begin
      @(negedge clock); #1;
      model_clr = 1'b0;
      if (obs !== IDLE) begin
        miscompares++;
        $display("FAIL reset_hold: got %b want %b", obs, IDLE);
      end
      vectors++;
    end
    @(negedge clock);
    resetn = 1'b1; #1;
    if (obs !== FETCH) begin
      miscompares++;
      $display("FAIL reset_release_fetch: got %b want %b", obs, FETCH);
    end
    vectors++;
    #1 run = 1'b0;
  endtask

  task automatic test_mvi(input logic [2:0] idx, input logic [15:0] val);
    logic [7:0] onehot;
    onehot = 8'h01 << idx;
    @(negedge clock);
    run = 1'b1; ir = {3'b001, idx, 3'b000}; #1;
    if (obs !== FETCH) begin
      miscompares++;
      $display("FAIL mvi_fetch: got %b want %b", obs, FETCH);
    end
    vectors++;
    @(negedge clock);
    run = 1'b0; din = val; #1;
    exp_v = {1'b0, onehot, 1'b0, 1'b0, 1'b0, 4'd9, 1'b1};
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL mvi_t1 R%0d: got %b want %b", idx, obs, exp_v);
    end
    vectors++;
    @(negedge clock); #1;
    if (obs !== IDLE) begin
      miscompares++;
      $display("FAIL mvi_idle: got %b want %b", obs, IDLE);
    end
    vectors++;
    if (regs[idx] !== val) begin
      miscompares++;
      $display("FAIL mvi_reg R%0d: got %h want %h", idx, regs[idx], val);
    end
    vectors++;
  endtask

  task automatic test_sub();
    test_mvi(3'd4, 16'd7);
    test_mvi(3'd1, 16'd3);
    @(negedge clock);
    run = 1'b1; ir = 9'b011_100_001; #1;
    if (obs !== FETCH) begin
      miscompares++;
      $display("FAIL sub_fetch: got %b want %b", obs, FETCH);
    end
    vectors++;
    @(negedge clock);
    run = 1'b0; #1;
    exp_v = {1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd4, 1'b0};
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL sub_t1: got %b want %b", obs, exp_v);
    end
    vectors++;
    @(negedge clock); #1;
    exp_v = {1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0};
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL sub_t2: got %b want %b", obs, exp_v);
    end
    vectors++;
    @(negedge clock); #1;
    exp_v = {1'b0, 8'b0001_0000, 1'b0, 1'b0, 1'b0, 4'd8, 1'b1};
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL sub_t3: got %b want %b", obs, exp_v);
    end
    vectors++;
    @(negedge clock); #1;
    if (obs !== IDLE) begin
      miscompares++;
      $display("FAIL sub_idle: got %b want %b", obs, IDLE);
    end
    vectors++;
    if (regs[4] !== 16'd4) begin
      miscompares++;
      $display("FAIL sub_reg R4: got %h want %h", regs[4], 16'd4);
    end
    vectors++;
  endtask

  task automatic test_mvnz();
    test_mvi(3'd0, 16'h1234);
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clock);
      run = 1'b1; ir = 9'b100_101_000; g_nz = pass[0]; #1;
      if (obs !== FETCH) begin
        miscompares++;
        $display("FAIL mvnz_fetch g_nz=%0d: got %b want %b", pass, obs, FETCH);
      end
      vectors++;
      @(negedge clock);
      run = 1'b0; #1;
      if (pass == 0) exp_v = {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd9, 1'b1};
      else           exp_v = {1'b0, 8'b0010_0000, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1};
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL mvnz_t1 g_nz=%0d: got %b want %b", pass, obs, exp_v);
      end
      vectors++;
      @(negedge clock); #1;
      exp_v[15:0] = (pass == 0) ? 16'h0000 : 16'h1234;
      if (regs[5] !== exp_v[15:0]) begin
        miscompares++;
        $display("FAIL mvnz_reg R5 g_nz=%0d: got %h want %h", pass, regs[5], exp_v[15:0]);
      end
      vectors++;
    end
    g_nz = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    run = 1'b1; ir = 9'b000_001_000; #1;
    if (obs !== FETCH) begin
      miscompares++;
      $display("FAIL b2b_fetch1: got %b want %b", obs, FETCH);
    end
    vectors++;
    @(negedge clock); #1;
    exp_v = {1'b0, 8'b0000_0010, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1};
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL b2b_mv_t1: got %b want %b", obs, exp_v);
    end
    vectors++;
    @(negedge clock);
    ir = 9'b010_001_001; #1;
    if (obs !== FETCH) begin
      miscompares++;
      $display("FAIL b2b_fetch2: got %b want %b", obs, FETCH);
    end
    vectors++;
    @(negedge clock);
    run = 1'b0; #1;
    exp_v = {1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0};
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL b2b_add_t1: got %b want %b", obs, exp_v);
    end
    vectors++;
    @(negedge clock); #1;
    exp_v = {1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0};
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL b2b_add_t2: got %b want %b", obs, exp_v);
    end
    vectors++;
    #1 resetn = 1'b0;
    @(negedge clock); #1;
    if (obs !== IDLE) begin
      miscompares++;
      $display("FAIL abort_reset_cycle: got %b want %b", obs, IDLE);
    end
    vectors++;
    resetn = 1'b1; run = 1'b1; #1;
    if (obs !== FETCH) begin
      miscompares++;
      $display("FAIL abort_back_in_t0: got %b want %b", obs, FETCH);
    end
    vectors++;
    run = 1'b0;
    if (regs[1] !== 16'h1234) begin
      miscompares++;
      $display("FAIL abort_reg R1: got %h want %h", regs[1], 16'h1234);
    end
    vectors++;
  endtask

  task automatic test_nop();
    for (int op = 5; op < 8; op++) begin
      @(negedge clock);
      run = 1'b1; ir = {op[2:0], 3'b011, 3'b010}; #1;
      if (obs !== FETCH) begin
        miscompares++;
        $display("FAIL nop_fetch op=%0d: got %b want %b", op, obs, FETCH);
      end
      vectors++;
      @(negedge clock);
      run = 1'b0; #1;
      exp_v = {1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd9, 1'b1};
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL nop_t1 op=%0d: got %b want %b", op, obs, exp_v);
      end
      vectors++;
      @(negedge clock); #1;
      if (obs !== IDLE) begin
        miscompares++;
        $display("FAIL nop_idle op=%0d: got %b want %b", op, obs, IDLE);
      end
      vectors++;
    end
  endtask

  initial begin
    test_reset();
    test_mvi(3'd2, 16'h00A5);
    test_sub();
    test_mvnz();
    test_back_to_back();
    test_nop();
    @(negedge clock); #4;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/proc_control.md
Name: proc_control

Overview:
- Control FSM for the simple 16-bit processor datapath.
- Sequences the 4-bit bus-mux select (R0–R7 = 0–7, G = 8, DIN = 9, any other code clears the bus).
- Drives the register load enables, A/G latches and the add/sub control.
- Fetches a 9-bit instruction IR = {III, XXX, YYY} from DIN and executes it over 2–4 cycles, then pulses done.

Parameters:
- NREG, 8, number of general registers (one-hot r_in width).
- SEL_G, 8, mux select code for G.
- SEL_DIN, 9, mux select code for DIN.

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- resetn  in  1  synchronous active-low reset; one clock, reset is synchronous and active-low.
- run  in  1  start request; sampled only in T0.
- ir  in  9  instruction register contents {III[8:6], XXX[5:3], YYY[2:0]}.
- g_nz  in  1  G register non-zero flag (used by mvnz).
- ir_in  out  1  IR load enable.
- r_in  out  NREG  one-hot register load enables, bit n = Rn.
- a_in  out  1  A latch load enable.
- g_in  out  1  G latch load enable.
- add_sub  out  1  ALU op: 0 = add, 1 = sub.
- select  out  4  bus mux select.
- done  out  1  instruction complete, one cycle per instruction.

Behaviour:
- State register is 2 bits, states T0–T3. All outputs are combinational decodes of state, ir, run and g_nz.
- Non-asserted defaults: all enables 0, add_sub = 0, done = 0, select = SEL_DIN.
- Reset: resetn low at a rising edge forces T0. T0 with run = 0 gives all outputs at defaults. Reset wins over every other transition, including mid-instruction; no register writes occur in the cycle after reset.
- T0 (fetch):
  - select = SEL_DIN.
  - If run = 1: ir_in = 1, next state T1.
  - Else stay in T0 with ir_in = 0.
- T1, decoded on III:
  - 000 mv Rx,Ry: select = YYY, r_in[XXX] = 1, done = 1, next T0.
  - 001 mvi Rx,#D: select = SEL_DIN, r_in[XXX] = 1, done = 1, next T0. The immediate is on DIN this cycle.
  - 010 add / 011 sub: select = XXX, a_in = 1, next T2.
  - 100 mvnz Rx,Ry: done = 1, next T0. If g_nz = 1, select = YYY and r_in[XXX] = 1. If g_nz = 0, no write and select = default.
  - 101–111: treated as NOP; done = 1, no enables, next T0.
- T2 (add/sub only):
  - select = YYY, g_in = 1, next T3.
  - add_sub = III[0] (add = 0, sub = 1).
- T3 (add/sub only):
  - select = SEL_G, r_in[XXX] = 1, done = 1, next T0.
- Latency from the run-sampled edge to the done cycle:
  - mv, mvi, mvnz, NOP: 1 cycle after fetch (2 cycles total).
  - add, sub: 3 cycles after fetch (4 cycles total).
- run is ignored in T1–T3.
- Back-to-back: if run is still 1 when T0 is re-entered, the next fetch happens immediately with no idle cycle.
- Rx = Ry is legal; e.g. add R3,R3 doubles R3.
- r_in is one-hot or zero in every cycle. At most one of ir_in / a_in / g_in / r_in is asserted per cycle.
- done is asserted only on the last cycle of an instruction, and never in T0.
- An illegal state cannot occur with a 2-bit register. The implementation still routes every unlisted case to T0 with default outputs.

Decomposition:
- Shared package / header holds:
  - opcode constants OP_MV = 3'b000, OP_MVI = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b011, OP_MVNZ = 3'b100;
  - state encodings T0–T3;
  - select codes SEL_G and SEL_DIN, shared with the bus mux so both blocks agree on the encoding.
- One sub-module, dec3to8: 3-bit index plus enable, producing the one-hot 8-bit r_in.

Test Plan:
- Reset: hold resetn = 0 for 2 cycles with run = 1 → state T0, ir_in = 0 during reset, r_in = 0, done = 0, select = 9. Release → ir_in = 1 in the first T0 cycle.
- mvi R2,#0x00A5:
  - run = 1 with DIN = 9'b001_010_000 → ir_in in T0.
  - Next cycle: select = 9, r_in = 8'b0000_0100, done = 1.
  - Model R2 = 0x00A5.
- sub R4,R1 with R4 = 7, R1 = 3 (ir = 011_100_001):
  - T1: select = 4, a_in = 1.
  - T2: select = 1, g_in = 1, add_sub = 1.
  - T3: select = 8, r_in = 8'b0001_0000, done = 1.
  - Model R4 = 4.
- mvnz R5,R0:
  - g_nz = 0 → T1 gives done = 1, r_in = 0.
  - Repeat with g_nz = 1 → select = 0, r_in = 8'b0010_0000.
- Back-to-back and abort:
  - run held high through mv R1,R0 then add R1,R1 → second ir_in in the cycle right after the first done.
  - Assert resetn = 0 during T2 of the add → T0 next cycle, no g_in or r_in pulse after the reset edge.
- Opcode 111 → done = 1 in T1, all enables 0.
- Across all directed tests, r_in is one-hot or zero every cycle.
